// File: rtl/mips_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, next-PC source
// selection and the redirect request bundle.
package mips_pkg;
  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'd0;
  localparam int          JR_W         = 27;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_JAL    = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_BRANCH = 3'd4
  } sel_e;

  typedef struct packed {
    logic branch;
    logic jr;
    logic jump;
    logic jal;
  } redir_req_t;

  // Branch > JR > Jump > Jal > sequential
  function automatic sel_e pick_sel(input redir_req_t r);
    if (r.branch)    return SEL_BRANCH;
    else if (r.jr)   return SEL_JR;
    else if (r.jump) return SEL_JUMP;
    else if (r.jal)  return SEL_JAL;
    else             return SEL_SEQ;
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: priority-selects among redirect sources and flags
// whether the chosen source is a redirect.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  redir_req_t        req,
  input  logic [ADDR_W-1:0] jal_target,
  input  logic [ADDR_W-1:0] jump_offset,
  input  logic [JR_W-1:0]   jr_target,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redir
);
  logic [ADDR_W-1:0] pc_inc;
  sel_e              sel;

  assign pc_inc = pc + ADDR_W'(1);
  assign sel    = pick_sel(req);
  assign redir  = (sel != SEL_SEQ);

  always_comb begin
    next_pc = pc_inc;
    case (sel)
      SEL_BRANCH: next_pc = pc_inc + branch_offset;
      SEL_JR:     next_pc = ADDR_W'(jr_target);
      SEL_JUMP:   next_pc = pc_inc + jump_offset;
      SEL_JAL:    next_pc = jal_target + ADDR_W'(1);
      default:    next_pc = pc_inc;
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: BOOT/FETCH/REDIRECT/HALT FSM,
// imem handshake with a bounded wait, and a one-cycle flush after redirects.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              jal,
  input  logic              jump,
  input  logic              jr,
  input  logic              branch,
  input  logic [ADDR_W-1:0] jal_target,
  input  logic [ADDR_W-1:0] jump_offset,
  input  logic [JR_W-1:0]   jr_target,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_req,
  output logic              flush,
  output logic              timeout
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  redir_req_t        req;
  logic [ADDR_W-1:0] next_pc;
  logic              redir;

  assign req = '{branch: branch, jr: jr, jump: jump, jal: jal};

  pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
    .pc            (pc_q),
    .req           (req),
    .jal_target    (jal_target),
    .jump_offset   (jump_offset),
    .jr_target     (jr_target),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .redir         (redir)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (!stall) begin
          if (imem_ready) begin
            wait_cnt_d = '0;
            pc_d       = next_pc;
            if (redir) state_d = ST_REDIRECT;
          end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            timeout_d  = 1'b1;
            state_d    = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      // Bubble cycle is unconditional so a stall cannot stretch the flush
      ST_REDIRECT: state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pc        = pc_q;
  assign fetch_req = (state_q == ST_FETCH);
  assign flush     = (state_q == ST_REDIRECT);
  assign timeout   = timeout_q;
endmodule
